multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  OPCODE_W, 6, opcode width
  CNT_W, 16, retired-instruction counter width
  ENABLE_JUMP, 1, 1 = decode j (6'b000010); 0 = treat j as illegal
  ADDI_OP, 6'b000111, addi opcode encoding
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clock  in  1  single clock; all state changes on its rising edge
  reset  in  1  synchronous, active-high reset
  opcode  in  OPCODE_W  instruction opcode from the IR; valid in DECODE
  mem_ready  in  1  memory handshake: access completes in a cycle where it is 1
  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
  ALUOp, ALUSrcB, PCSource  out  2 each  datapath selects
  state  out  4  current FSM state, for debug
  illegal_op  out  1  one-cycle pulse on an undecodable opcode
  instr_count  out  CNT_W  number of retired instructions

Function
REQ-003 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Outputs decode from state only.
- Exception: IRWrite and PCWrite in FETCH equal mem_ready.
REQ-004 Any output not listed for a state SHALL be 0.
REQ-005 FETCH SHALL drive MemRead=1, ALUSrcB=01, with IorD, ALUSrcA, ALUOp and PCSource all 0.
- Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-006 DECODE SHALL drive ALUSrcB=11, latch opcode into an internal register and branch on it:
- 000000 -> EXEC
- 100011 or 101011 -> MEMADR
- 000100 -> BRANCH
- ADDI_OP -> ADDIEX
- 000010 -> JUMP (only if ENABLE_JUMP=1)
- anything else -> FETCH, with illegal_op=1 in the following cycle only
REQ-007 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10; go to MEMRD for lw, MEMWR for sw, decided by the latched opcode.
REQ-008 MEMRD SHALL drive MemRead=1, IorD=1; hold until mem_ready=1, then go to MEMWB.
REQ-009 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-010 MEMWR SHALL drive MemWrite=1, IorD=1; hold until mem_ready=1, then go to FETCH.
REQ-011 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB.
REQ-012 RWB SHALL drive RegWrite=1, RegDst=1, then go to FETCH.
REQ-013 BRANCH SHALL drive ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-014 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB.
REQ-015 ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-016 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-017 Every transition into FETCH from a completing state SHALL increment instr_count by 1.
- Completing states: MEMWB, MEMWR with mem_ready=1, RWB, BRANCH, ADDIWB, JUMP.
- The illegal-opcode path SHALL NOT increment it.
- instr_count wraps modulo 2^CNT_W.
REQ-018 With ideal memory (mem_ready=1 throughout), cycles per instruction SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-019 opcode changes outside DECODE SHALL NOT affect control flow.

Reset
REQ-020 A rising clock edge with reset=1 SHALL set:
- state to FETCH
- instr_count, illegal_op and the latched opcode to 0
REQ-021 While reset=1, all datapath control outputs SHALL be 0, including the FETCH outputs.
REQ-022 Reset mid-instruction, including during a mem_ready stall, SHALL abandon that instruction with no increment.
- The first FETCH access begins in the cycle after reset deasserts.

Structure
REQ-023 A shared package multicycle_pkg SHALL hold:
- the 4-bit state encodings
- opcode constants (R-type, lw, sw, beq, j)
- ALUOp, ALUSrcB and PCSource constants
REQ-024 One sub-module, mc_output_decode, SHALL map (state, mem_ready, reset) to the datapath controls combinationally.
- The top level holds the state register, latched opcode, counter and illegal_op.

Verification
REQ-025 The bench SHALL cover these scenarios:
- lw, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5; instr_count 0->1.
- sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite held 4 cycles; 7 cycles total; no RegWrite.
- opcode 6'b111111 -> DECODE then FETCH; illegal_op high exactly 1 cycle; instr_count unchanged.
- ENABLE_JUMP=0 with j -> illegal_op pulse; ENABLE_JUMP=1 -> JUMP state, PCWrite=1, PCSource=10.
- reset asserted during a MEMRD stall -> next cycle state=FETCH, outputs 0, instr_count=0; CNT_W=4 with 16 R-types -> count wraps to 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcode values, datapath select codes and the bundled control word.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational map from FSM state to datapath controls; everything is
// forced low while reset is high.
module mc_output_decode
    import multicycle_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    input  logic   reset,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    // IR load and PC+4 only commit when the fetch completes
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                DECODE: begin
                    ctrl.alu_src_b = SRCB_BRIMM;
                end
                MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                RWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                ADDIWB: begin
                    ctrl.reg_write = 1'b1;
                end
                JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: state register, latched opcode,
// retired-instruction counter and illegal-opcode pulse.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int                    OPCODE_W    = 6,
    parameter int                    CNT_W       = 16,
    parameter int                    ENABLE_JUMP = 1,
    parameter logic [OPCODE_W-1:0]   ADDI_OP     = 6'b000111
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic                ALUSrcA,
    output logic                RegWrite,
    output logic                RegDst,
    output logic [1:0]          ALUOp,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [3:0]          state,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    instr_count
);

    localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] OPC_LW    = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] OPC_SW    = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] OPC_J     = OPCODE_W'(OP_J);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                illegal_q, illegal_d;
    logic                retire;
    ctrl_t               ctrl;

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        count_d   = count_q;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                opcode_d = opcode;
                if (opcode == OPC_RTYPE)                         state_d = EXEC;
                else if (opcode == OPC_LW || opcode == OPC_SW)   state_d = MEMADR;
                else if (opcode == OPC_BEQ)                      state_d = BRANCH;
                else if (opcode == ADDI_OP)                      state_d = ADDIEX;
                else if (ENABLE_JUMP != 0 && opcode == OPC_J)    state_d = JUMP;
                else begin
                    state_d   = FETCH;
                    illegal_d = 1'b1;
                end
            end
            // Only the latched copy is trusted once DECODE has passed
            MEMADR: state_d = (opcode_q == OPC_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXEC:   state_d = RWB;
            ADDIEX: state_d = ADDIWB;
            MEMWB, RWB, BRANCH, ADDIWB, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        if (retire) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH;
            opcode_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    mc_output_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .reset     (reset),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign state       = state_q;
    assign illegal_op  = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three instances (default, no-jump, 4-bit
// counter) driven in lockstep; directed table, corner sequences, random run.
module tb_multicycle_control;
    import multicycle_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic        mem_ready = 1'b1;

    // ctrl bit order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
    // ALUSrcA RegWrite RegDst ALUOp[1:0] ALUSrcB[1:0] PCSource[1:0]
    logic [2:0][15:0] ctrl;
    logic [2:0][3:0]  st;
    logic [2:0]       ill;
    logic [2:0][15:0] cnt;

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int EJ = (gi == 1) ? 0 : 1;
        localparam int CW = (gi == 2) ? 4 : 16;
        logic [CW-1:0] cnt_w;
        multicycle_control #(
            .OPCODE_W(6), .CNT_W(CW), .ENABLE_JUMP(EJ), .ADDI_OP(6'b000111)
        ) u_dut (
            .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
            .PCWrite(ctrl[gi][15]), .PCWriteCond(ctrl[gi][14]), .IorD(ctrl[gi][13]),
            .MemRead(ctrl[gi][12]), .MemWrite(ctrl[gi][11]), .MemtoReg(ctrl[gi][10]),
            .IRWrite(ctrl[gi][9]), .ALUSrcA(ctrl[gi][8]), .RegWrite(ctrl[gi][7]),
            .RegDst(ctrl[gi][6]), .ALUOp(ctrl[gi][5:4]), .ALUSrcB(ctrl[gi][3:2]),
            .PCSource(ctrl[gi][1:0]), .state(st[gi]), .illegal_op(ill[gi]),
            .instr_count(cnt_w)
        );
        assign cnt[gi] = 16'(cnt_w);
    end

    int n_vec = 0;
    int n_bad = 0;
    int model_cnt = 0;
    logic model_ill = 1'b0;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [32];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Control word each state must present, straight from the state descriptions
    function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic mr);
        case (s)
            FETCH:  return mr ? 16'h9204 : 16'h1004;
            DECODE: return 16'h000C;
            MEMADR: return 16'h0108;
            MEMRD:  return 16'h3000;
            MEMWB:  return 16'h0480;
            MEMWR:  return 16'h2800;
            EXEC:   return 16'h0120;
            RWB:    return 16'h00C0;
            BRANCH: return 16'h4111;
            ADDIEX: return 16'h0108;
            ADDIWB: return 16'h0080;
            JUMP:   return 16'h8002;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    task automatic drive(input logic r, input logic [5:0] op, input logic mr);
        @(negedge clock);
        reset = r; opcode = op; mem_ready = mr;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, rnd_op(), 1'b1);
        for (int i = 0; i < 3; i++) chk($sformatf("reset_ctrl%0d", i), ctrl[i], 16'h0);
        model_cnt = 0;
        model_ill = 1'b0;
    endtask

    // One cycle of the instance-0 reference: expected state plus derived outputs
    task automatic step(input logic [3:0] es, input logic mr, input logic [5:0] op);
        drive(1'b0, op, mr);
        chk("state", 16'(st[0]), 16'(es));
        chk($sformatf("ctrl_s%0d", es), ctrl[0], exp_ctrl(es, mr));
        chk("illegal_op", 16'(ill[0]), 16'(model_ill));
        chk("instr_count", cnt[0], 16'(model_cnt));
        chk("instr_count_w4", cnt[2], 16'(model_cnt % 16));
        model_ill = 1'b0;
    endtask

    // Instruction-level model: opcode decides the state path, stalls stretch
    // the memory-wait states, legal completions bump the count.
    task automatic run_instr(input logic [5:0] op, input int max_stall);
        int fs;
        int ms;
        logic [3:0] mst;
        fs = int'($urandom_range(max_stall, 0));
        for (int k = 0; k < fs; k++) step(FETCH, 1'b0, rnd_op());
        step(FETCH, 1'b1, rnd_op());
        step(DECODE, 1'($urandom), op);
        if (op == OP_LW || op == OP_SW) begin
            step(MEMADR, 1'($urandom), rnd_op());
            mst = (op == OP_LW) ? 4'(MEMRD) : 4'(MEMWR);
            ms = int'($urandom_range(max_stall, 0));
            for (int k = 0; k < ms; k++) step(mst, 1'b0, rnd_op());
            step(mst, 1'b1, rnd_op());
            if (op == OP_LW) step(MEMWB, 1'($urandom), rnd_op());
            model_cnt++;
        end else if (op == OP_RTYPE) begin
            step(EXEC, 1'($urandom), rnd_op());
            step(RWB, 1'($urandom), rnd_op());
            model_cnt++;
        end else if (op == OP_BEQ) begin
            step(BRANCH, 1'($urandom), rnd_op());
            model_cnt++;
        end else if (op == 6'b000111) begin
            step(ADDIEX, 1'($urandom), rnd_op());
            step(ADDIWB, 1'($urandom), rnd_op());
            model_cnt++;
        end else if (op == OP_J) begin
            step(JUMP, 1'($urandom), rnd_op());
            model_cnt++;
        end else begin
            model_ill = 1'b1;
        end
    endtask

    initial begin
        logic [5:0] pick_op;

        tbl[0]  = '{1'b1, 6'h00, 1'b1, 4'(FETCH),  16'h0000, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 6'h2B, 1'b1, 4'(FETCH),  16'h9204, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 6'h23, 1'b0, 4'(DECODE), 16'h000C, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 6'h00, 1'b1, 4'(MEMADR), 16'h0108, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 6'h3F, 1'b1, 4'(MEMRD),  16'h3000, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 6'h04, 1'b0, 4'(MEMWB),  16'h0480, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 6'h00, 1'b0, 4'(FETCH),  16'h1004, 1'b0, 16'd1};
        tbl[7]  = '{1'b0, 6'h00, 1'b1, 4'(FETCH),  16'h9204, 1'b0, 16'd1};
        tbl[8]  = '{1'b0, 6'h2B, 1'b1, 4'(DECODE), 16'h000C, 1'b0, 16'd1};
        tbl[9]  = '{1'b0, 6'h23, 1'b0, 4'(MEMADR), 16'h0108, 1'b0, 16'd1};
        tbl[10] = '{1'b0, 6'h23, 1'b0, 4'(MEMWR),  16'h2800, 1'b0, 16'd1};
        tbl[11] = '{1'b0, 6'h00, 1'b0, 4'(MEMWR),  16'h2800, 1'b0, 16'd1};
        tbl[12] = '{1'b0, 6'h04, 1'b0, 4'(MEMWR),  16'h2800, 1'b0, 16'd1};
        tbl[13] = '{1'b0, 6'h07, 1'b1, 4'(MEMWR),  16'h2800, 1'b0, 16'd1};
        tbl[14] = '{1'b0, 6'h00, 1'b1, 4'(FETCH),  16'h9204, 1'b0, 16'd2};
        tbl[15] = '{1'b0, 6'h3F, 1'b1, 4'(DECODE), 16'h000C, 1'b0, 16'd2};
        tbl[16] = '{1'b0, 6'h00, 1'b0, 4'(FETCH),  16'h1004, 1'b1, 16'd2};
        tbl[17] = '{1'b0, 6'h00, 1'b1, 4'(FETCH),  16'h9204, 1'b0, 16'd2};
        tbl[18] = '{1'b0, 6'h04, 1'b1, 4'(DECODE), 16'h000C, 1'b0, 16'd2};
        tbl[19] = '{1'b0, 6'h23, 1'b0, 4'(BRANCH), 16'h4111, 1'b0, 16'd2};
        tbl[20] = '{1'b0, 6'h00, 1'b1, 4'(FETCH),  16'h9204, 1'b0, 16'd3};
        tbl[21] = '{1'b0, 6'h02, 1'b1, 4'(DECODE), 16'h000C, 1'b0, 16'd3};
        tbl[22] = '{1'b0, 6'h00, 1'b0, 4'(JUMP),   16'h8002, 1'b0, 16'd3};
        tbl[23] = '{1'b0, 6'h00, 1'b1, 4'(FETCH),  16'h9204, 1'b0, 16'd4};
        tbl[24] = '{1'b0, 6'h07, 1'b1, 4'(DECODE), 16'h000C, 1'b0, 16'd4};
        tbl[25] = '{1'b0, 6'h2B, 1'b1, 4'(ADDIEX), 16'h0108, 1'b0, 16'd4};
        tbl[26] = '{1'b0, 6'h00, 1'b0, 4'(ADDIWB), 16'h0080, 1'b0, 16'd4};
        tbl[27] = '{1'b0, 6'h00, 1'b1, 4'(FETCH),  16'h9204, 1'b0, 16'd5};
        tbl[28] = '{1'b0, 6'h00, 1'b1, 4'(DECODE), 16'h000C, 1'b0, 16'd5};
        tbl[29] = '{1'b0, 6'h3F, 1'b1, 4'(EXEC),   16'h0120, 1'b0, 16'd5};
        tbl[30] = '{1'b0, 6'h00, 1'b0, 4'(RWB),    16'h00C0, 1'b0, 16'd5};
        tbl[31] = '{1'b0, 6'h00, 1'b0, 4'(FETCH),  16'h1004, 1'b0, 16'd6};

        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].mr);
            chk($sformatf("tbl%0d_state", i), 16'(st[0]), 16'(tbl[i].st));
            chk($sformatf("tbl%0d_ctrl", i), ctrl[0], tbl[i].ctl);
            chk($sformatf("tbl%0d_ill", i), 16'(ill[0]), 16'(tbl[i].ill));
            chk($sformatf("tbl%0d_cnt", i), cnt[0], tbl[i].cnt);
            $display("vector %0d: state=%0d ctrl=%h ill=%b cnt=%0d", i, st[0], ctrl[0], ill[0], cnt[0]);
        end

        // j decoded by the default instance, rejected when jumps are disabled
        do_reset();
        drive(1'b0, 6'h15, 1'b1);
        drive(1'b0, OP_J, 1'b1);
        drive(1'b0, 6'h00, 1'b1);
        chk("j_state", 16'(st[0]), 16'(JUMP));
        chk("j_ctrl", ctrl[0], 16'h8002);
        chk("nj_state", 16'(st[1]), 16'(FETCH));
        chk("nj_ill", 16'(ill[1]), 16'd1);
        chk("j_ill", 16'(ill[0]), 16'd0);
        drive(1'b0, 6'h00, 1'b1);
        chk("nj_ill_one_cycle", 16'(ill[1]), 16'd0);
        chk("j_cnt", cnt[0], 16'd1);
        chk("nj_cnt", cnt[1], 16'd0);
        $display("jump check: state=%0d nj_state=%0d cnt=%0d nj_cnt=%0d", st[0], st[1], cnt[0], cnt[1]);

        // Reset while lw is stalled in MEMRD abandons it and clears the count
        do_reset();
        run_instr(OP_RTYPE, 0);
        step(FETCH, 1'b1, 6'h00);
        step(DECODE, 1'b1, OP_LW);
        step(MEMADR, 1'b1, 6'h00);
        step(MEMRD, 1'b0, 6'h00);
        step(MEMRD, 1'b0, 6'h00);
        drive(1'b1, 6'h00, 1'b0);
        chk("stall_rst_ctrl", ctrl[0], 16'h0000);
        chk("stall_rst_cnt_before", cnt[0], 16'd1);
        drive(1'b0, 6'h00, 1'b1);
        chk("stall_rst_state", 16'(st[0]), 16'(FETCH));
        chk("stall_rst_cnt", cnt[0], 16'd0);
        chk("stall_rst_fetch_ctrl", ctrl[0], 16'h9204);
        $display("reset-in-stall: state=%0d cnt=%0d ctrl=%h", st[0], cnt[0], ctrl[0]);

        // 16 R-types wrap the 4-bit counter
        do_reset();
        for (int i = 0; i < 16; i++) run_instr(OP_RTYPE, 0);
        drive(1'b0, 6'h00, 1'b0);
        chk("wrap_cnt_w4", cnt[2], 16'd0);
        chk("wrap_cnt_w16", cnt[0], 16'd16);
        $display("wrap check: cnt_w4=%0d cnt_w16=%0d", cnt[2], cnt[0]);

        // Random instruction stream with random memory stalls
        do_reset();
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(7, 0))
                0: pick_op = OP_RTYPE;
                1: pick_op = OP_LW;
                2: pick_op = OP_SW;
                3: pick_op = OP_BEQ;
                4: pick_op = 6'b000111;
                5: pick_op = OP_J;
                6: pick_op = rnd_op();
                default: pick_op = 6'h3F;
            endcase
            run_instr(pick_op, 3);
            $display("instr %0d: op=%b count=%0d", i, pick_op, model_cnt);
        end
        step(FETCH, 1'b0, 6'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
